div_unit: RTL

- Multi-cycle radix-2 restoring divider in the execute stage of the 5-stage MIPS pipeline.
- Executes DIV/DIVU and drives the pipeline divide stall (div_stallE), which freezes F/D/E and bubbles M until the result is ready.
- Result is written to HI/LO as {remainder, quotient} via the normal E->M path.

---
 rtl/div_unit_pkg.sv | 24 ++
 rtl/div_step.sv | 30 +++
 rtl/div_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the execute-stage divider: FSM encoding, HI/LO field layout, decoder funct codes.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    localparam int unsigned CPU_XLEN = 32;
    localparam int unsigned LO_LSB   = 0;
    localparam int unsigned LO_MSB   = CPU_XLEN - 1;
    localparam int unsigned HI_LSB   = CPU_XLEN;
    localparam int unsigned HI_MSB   = 2 * CPU_XLEN - 1;

    localparam logic [5:0] FUNCT_DIV  = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU = 6'h1B;

    typedef struct packed {
        logic [CPU_XLEN-1:0] hi;
        logic [CPU_XLEN-1:0] lo;
    } hilo_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial remainder, trial-subtract, restore on borrow.
module div_step
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_nxt_c,
    output logic [WIDTH-1:0] quo_nxt_c
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign diff    = shifted - {1'b0, div_i};

    // The partial remainder stays below the divisor, so an accepted difference always fits in WIDTH bits.
    always_comb begin
        rem_nxt_c = shifted[WIDTH-1:0];
        quo_nxt_c = {quo_i[WIDTH-2:0], 1'b0};
        if (shifted >= {1'b0, div_i}) begin
            rem_nxt_c = diff[WIDTH-1:0];
            quo_nxt_c = {quo_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU with pipeline stall; result is {remainder, quotient}.
// Optional DIV_ZERO_FAST_EN: a zero divisor seen at capture skips the iterations and finishes immediately.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opa_i,
    input  logic [WIDTH-1:0]   opb_i,
    input  logic               cancel_i,
    output logic               stall_o,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o
);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               ready_q, ready_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0]   step_rem, step_quo;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic               cap_qneg, cap_rneg;

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (WIDTH'(0) - v) : v;
    endfunction

    assign abs_a    = (signed_i && opa_i[WIDTH-1]) ? (WIDTH'(0) - opa_i) : opa_i;
    assign abs_b    = (signed_i && opb_i[WIDTH-1]) ? (WIDTH'(0) - opb_i) : opb_i;
    assign cap_qneg = signed_i & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
    assign cap_rneg = signed_i & opa_i[WIDTH-1];

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .div_i     (dvs_q),
        .rem_nxt_c (step_rem),
        .quo_nxt_c (step_quo)
    );

    // Next-state and datapath; result is registered on entry to DONE so it is valid while stall drops.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        ready_d  = 1'b0;
        result_d = result_q;

        case (state_q)
            DIV_IDLE: begin
                if (start_i) begin
                    dvs_d   = abs_b;
                    quo_d   = abs_a;
                    rem_d   = '0;
                    qneg_d  = cap_qneg;
                    rneg_d  = cap_rneg;
                    cnt_d   = '0;
                    state_d = DIV_BUSY;
`ifdef DIV_ZERO_FAST_EN
                    if (opb_i == '0) begin
                        state_d  = DIV_DONE;
                        ready_d  = 1'b1;
                        result_d = {apply_sign(abs_a, cap_rneg), apply_sign('1, cap_qneg)};
                    end
`endif
                end
            end
            DIV_BUSY: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d  = DIV_DONE;
                    ready_d  = 1'b1;
                    result_d = {apply_sign(step_rem, rneg_q), apply_sign(step_quo, qneg_q)};
                end
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase

        // Flush wins over everything, including a start in the same cycle.
        if (cancel_i) begin
            state_d  = DIV_IDLE;
            ready_d  = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            ready_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            ready_q  <= ready_d;
            result_q <= result_d;
        end
    end

    // Combinational so the hazard unit freezes the pipe in the cycle the divide enters E.
    assign stall_o  = start_i & (state_q != DIV_DONE) & ~cancel_i;
    assign ready_o  = ready_q;
    assign result_o = result_q;

endmodule
